conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Parametrised successor to the fixed-count convolution controller. It sequences one convolution output through load, multiply, and a configurable number of adder-tree levels, then a store. It drives the input-matrix RAM, the filter ROM, the datapath stage enables and the result FIFO. New behaviour: all phase lengths and the output count are generics, FIFO back-pressure (`fifo_full`) stalls the store, and `abort` cancels a job mid-flight.

## Interface
Parameters:
- `ADDR_W`, 10: input RAM address width.
- `ROM_DEPTH`, 2: filter ROM words per output. `rom_addr` width is `max(1, clog2(ROM_DEPTH))`.
- `LOAD_CYCLES`, 2: LOAD phase length. Must be ≥1.
- `MULT_CYCLES`, 16: MULT phase length. Must be ≥1.
- `ADD_LEVELS`, 4: number of adder-tree levels. Must be ≥1.
- `ADD_CYCLES`, 8: cycles per adder level. Must be ≥1.
- `NUM_OUTPUTS`, 256: outputs per job. Must be ≥1. `CNT_W = clog2(NUM_OUTPUTS+1)`.

Ports:
- `clk` in 1: the only clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a job. Sampled only in IDLE.
- `abort` in 1: cancel the current job.
- `fifo_full` in 1: result FIFO cannot accept a write.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a job completes.
- `ram_en` out 1: input RAM enable.
- `ram_addr` out `ADDR_W`: input RAM address.
- `rom_en` out 1: filter ROM enable.
- `rom_addr` out `clog2(ROM_DEPTH)`: filter ROM address.
- `dp_mult` out 1: multiplier stage enable.
- `dp_add` out `ADD_LEVELS`: one-hot adder-level enable.
- `fifo_wr` out 1: result FIFO write strobe.
- `fifo_rd` out 1: result FIFO read-out request.
- `out_count` out `CNT_W`: number of outputs stored in the current job.

## Operation
- States: IDLE, LOAD, MULT, ADD, STORE, FINISH.
- Internal counters:
  - `phase`: cycles elapsed in the current state.
  - `level`: current adder level, 0 to `ADD_LEVELS-1`.
- All outputs are Moore outputs, decoded from registered state and counters. There is no combinational path from any input to any output.
- IDLE:
  - `busy=0`.
  - When `start=1` and `abort=0`: go to LOAD; clear `ram_addr`, `rom_addr` and `out_count` to 0.
- LOAD:
  - `ram_en=1`, `rom_en=1`.
  - At the end of every LOAD cycle, `ram_addr` increments by 1, wrapping modulo 2^`ADDR_W`.
  - At the end of every LOAD cycle, `rom_addr` increments by 1, wrapping from `ROM_DEPTH-1` to 0.
  - After `LOAD_CYCLES` cycles: go to MULT; reset `rom_addr` to 0.
  - `ram_addr` does not reset between outputs. Output n reads addresses n·`LOAD_CYCLES` .. n·`LOAD_CYCLES`+`LOAD_CYCLES`-1 (mod 2^`ADDR_W`).
- MULT: `dp_mult=1` for `MULT_CYCLES` cycles, then go to ADD with `level=0`.
- ADD:
  - `dp_add` = one-hot bit `level`.
  - Each level lasts `ADD_CYCLES` cycles.
  - After the last cycle of level `ADD_LEVELS-1`, go to STORE.
- STORE:
  - While `fifo_full=1`: hold STORE with `fifo_wr=0`. The stall is unbounded.
  - First cycle with `fifo_full=0`: `fifo_wr=1` for exactly that cycle and `out_count` increments.
  - Then, if the new `out_count` equals `NUM_OUTPUTS`, go to FINISH; otherwise go to LOAD.
- FINISH:
  - `done=1` and `fifo_rd=1` for one cycle. `busy` stays 1.
  - Then go to IDLE.
  - `out_count` holds its value until the next start.
- Every enable output not listed for a state is 0 in that state.
- Priority: `reset` > `abort` > normal sequencing.
- `abort=1` in any non-IDLE state:
  - Go to IDLE on the next edge.
  - No `fifo_wr` in that cycle. Because outputs are Moore, a `fifo_wr` already high in that STORE cycle still completes.
  - No `done`, no `fifo_rd`.
  - `out_count` holds its value.
- `abort` in IDLE has no effect.
- `start` while `busy=1` is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `ram_en`, `rom_en`, `dp_mult`, `dp_add`, `fifo_wr`, `fifo_rd` all 0; `ram_addr`, `rom_addr`, `out_count` all 0; `phase` and `level` 0.
- A `start` sampled at edge E puts the block in LOAD, with `busy=1`, from cycle E+1.
- Cycles per output with no stall: P = `LOAD_CYCLES` + `MULT_CYCLES` + `ADD_LEVELS`·`ADD_CYCLES` + 1. With default parameters, P = 51.
- Job length: `busy` is high for `NUM_OUTPUTS`·P + 1 + (total stall cycles). With defaults and no stall, this is 13057 cycles.
- `done` is asserted in the last busy cycle. `busy` falls on the following cycle.
- A new `start` is accepted in the first IDLE cycle after FINISH.
- Reset asserted mid-job returns to reset values at the next edge.

## Test plan
Bench parameters for all scenarios unless stated: `LOAD_CYCLES=2`, `MULT_CYCLES=3`, `ADD_LEVELS=2`, `ADD_CYCLES=2`, `NUM_OUTPUTS=3`, `ROM_DEPTH=2`, giving P=10.

- **Basic job:** one-cycle `start` with `fifo_full=0` -> `busy` high for 31 cycles.
  - `fifo_wr` pulses at busy cycles 10, 20, 30.
  - `done` and `fifo_rd` pulse at cycle 31.
  - `out_count` reads 3 afterwards.
  - `ram_addr` during LOAD is 0,1 / 2,3 / 4,5; `rom_addr` is 0,1 for each output.
- **Stage enables:** per output, `dp_mult` high for 3 cycles; `dp_add`=01 for 2 cycles, then 10 for 2 cycles; no enable overlap in any cycle.
- **Back-pressure:** hold `fifo_full=1` for 5 cycles at the first STORE -> STORE held 5 extra cycles, single `fifo_wr` on the first free cycle, total busy 36 cycles.
- **Abort:**
  - `abort` in MULT of output 2 -> IDLE next cycle, no `done`, `out_count`=1.
  - A subsequent `start` runs a full 31-cycle job from `ram_addr` 0.
- **Start/abort/reset interaction:**
  - `start` and `abort` together in IDLE -> remains IDLE.
  - `start` while busy -> ignored.
  - `reset` mid-ADD -> all outputs at reset values next cycle.
- **Address wrap:** `ADDR_W=2`, `LOAD_CYCLES=3`, `NUM_OUTPUTS=2` -> LOAD addresses 0,1,2 then 3,0,1.

Source files
------------

// File: rtl/conv_sequencer.sv
// conv_sequencer: sequences convolution outputs through LOAD, MULT, a chain of
// adder-tree levels and a back-pressured STORE, driving RAM/ROM addresses, the
// datapath stage enables and the result FIFO strobes.
module conv_sequencer #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned ROM_DEPTH   = 2,
    parameter int unsigned LOAD_CYCLES = 2,
    parameter int unsigned MULT_CYCLES = 16,
    parameter int unsigned ADD_LEVELS  = 4,
    parameter int unsigned ADD_CYCLES  = 8,
    parameter int unsigned NUM_OUTPUTS = 256,
    localparam int unsigned RA_W  = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(NUM_OUTPUTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  rom_en,
    output logic [RA_W-1:0]       rom_addr,
    output logic                  dp_mult,
    output logic [ADD_LEVELS-1:0] dp_add,
    output logic                  fifo_wr,
    output logic                  fifo_rd,
    output logic [CNT_W-1:0]      out_count
);

    localparam int unsigned PH_LM  = (LOAD_CYCLES > MULT_CYCLES) ? LOAD_CYCLES : MULT_CYCLES;
    localparam int unsigned PH_MAX = (PH_LM > ADD_CYCLES) ? PH_LM : ADD_CYCLES;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned LV_W   = (ADD_LEVELS > 1) ? $clog2(ADD_LEVELS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MULT, S_ADD, S_STORE, S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [LV_W-1:0]       level_q, level_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic [RA_W-1:0]       rom_addr_q, rom_addr_d;
    logic [CNT_W-1:0]      out_count_q, out_count_d;
    logic                  fifo_wr_q, fifo_wr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ram_en_q, ram_en_d;
    logic                  rom_en_q, rom_en_d;
    logic                  dp_mult_q, dp_mult_d;
    logic [ADD_LEVELS-1:0] dp_add_q, dp_add_d;
    logic                  fifo_rd_q, fifo_rd_d;

    // Next state, counters, and output decode of the next state (outputs stay Moore)
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + PH_W'(1);
        level_d     = level_q;
        ram_addr_d  = ram_addr_q;
        rom_addr_d  = rom_addr_q;
        out_count_d = out_count_q;
        fifo_wr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (start && !abort) begin
                    state_d     = S_LOAD;
                    ram_addr_d  = '0;
                    rom_addr_d  = '0;
                    out_count_d = '0;
                end
            end
            S_LOAD: begin
                ram_addr_d = ram_addr_q + ADDR_W'(1);
                if (rom_addr_q == RA_W'(ROM_DEPTH - 1)) rom_addr_d = '0;
                else                                    rom_addr_d = rom_addr_q + RA_W'(1);
                if (phase_q == PH_W'(LOAD_CYCLES - 1)) begin
                    state_d    = S_MULT;
                    phase_d    = '0;
                    rom_addr_d = '0;
                end
            end
            S_MULT: begin
                if (phase_q == PH_W'(MULT_CYCLES - 1)) begin
                    state_d = S_ADD;
                    phase_d = '0;
                    level_d = '0;
                end
            end
            S_ADD: begin
                if (phase_q == PH_W'(ADD_CYCLES - 1)) begin
                    phase_d = '0;
                    if (level_q == LV_W'(ADD_LEVELS - 1)) begin
                        state_d = S_STORE;
                        level_d = '0;
                        // the write is committed as soon as the FIFO has room
                        if (!fifo_full) begin
                            fifo_wr_d   = 1'b1;
                            out_count_d = out_count_q + CNT_W'(1);
                        end
                    end else begin
                        level_d = level_q + LV_W'(1);
                    end
                end
            end
            S_STORE: begin
                phase_d = '0;
                if (fifo_wr_q) begin
                    state_d = (out_count_q == CNT_W'(NUM_OUTPUTS)) ? S_FINISH : S_LOAD;
                end else if (!fifo_full) begin
                    fifo_wr_d   = 1'b1;
                    out_count_d = out_count_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase

        // abort wins over sequencing but leaves the address/count registers alone
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            phase_d     = '0;
            level_d     = '0;
            fifo_wr_d   = 1'b0;
            ram_addr_d  = ram_addr_q;
            rom_addr_d  = rom_addr_q;
            out_count_d = out_count_q;
        end

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FINISH);
        fifo_rd_d = (state_d == S_FINISH);
        ram_en_d  = (state_d == S_LOAD);
        rom_en_d  = (state_d == S_LOAD);
        dp_mult_d = (state_d == S_MULT);
        dp_add_d  = (state_d == S_ADD) ? (ADD_LEVELS'(1) << level_d) : '0;
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            level_q     <= '0;
            ram_addr_q  <= '0;
            rom_addr_q  <= '0;
            out_count_q <= '0;
            fifo_wr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            rom_en_q    <= 1'b0;
            dp_mult_q   <= 1'b0;
            dp_add_q    <= '0;
            fifo_rd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            level_q     <= level_d;
            ram_addr_q  <= ram_addr_d;
            rom_addr_q  <= rom_addr_d;
            out_count_q <= out_count_d;
            fifo_wr_q   <= fifo_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_en_q    <= ram_en_d;
            rom_en_q    <= rom_en_d;
            dp_mult_q   <= dp_mult_d;
            dp_add_q    <= dp_add_d;
            fifo_rd_q   <= fifo_rd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_en    = ram_en_q;
    assign ram_addr  = ram_addr_q;
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign dp_mult   = dp_mult_q;
    assign dp_add    = dp_add_q;
    assign fifo_wr   = fifo_wr_q;
    assign fifo_rd   = fifo_rd_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Testbench for conv_sequencer: per-cycle comparison of all outputs against a
// schedule expanded from the phase lengths, with random back-pressure and noise.
module tb_conv_sequencer;

    localparam int LC = 2;
    localparam int MC = 3;
    localparam int AL = 2;
    localparam int AC = 2;
    localparam int NO = 3;
    localparam int RD = 2;
    localparam int AW = 10;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          ram_en;
        logic [AW-1:0] ram_addr;
        logic          rom_en;
        logic [0:0]    rom_addr;
        logic          dp_mult;
        logic [1:0]    dp_add;
        logic          fifo_wr;
        logic          fifo_rd;
        logic [1:0]    out_count;
    } obs_t;

    logic clk = 1'b0;
    logic reset, start, abort, fifo_full;
    logic busy, done, ram_en, rom_en, dp_mult, fifo_wr, fifo_rd;
    logic [AW-1:0] ram_addr;
    logic [0:0] rom_addr;
    logic [1:0] dp_add;
    logic [1:0] out_count;

    logic w_start, w_abort, w_fifo_full;
    logic w_busy, w_done, w_ram_en, w_rom_en, w_dp_mult, w_fifo_wr, w_fifo_rd;
    logic [1:0] w_ram_addr;
    logic [0:0] w_rom_addr;
    logic [1:0] w_dp_add;
    logic [1:0] w_out_count;

    obs_t obs;
    obs_t exp_q[$];
    bit   ff_q[$];
    obs_t idle_mask;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    conv_sequencer #(
        .ADDR_W(AW), .ROM_DEPTH(RD), .LOAD_CYCLES(LC), .MULT_CYCLES(MC),
        .ADD_LEVELS(AL), .ADD_CYCLES(AC), .NUM_OUTPUTS(NO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .fifo_full(fifo_full),
        .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr),
        .rom_en(rom_en), .rom_addr(rom_addr), .dp_mult(dp_mult), .dp_add(dp_add),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .out_count(out_count)
    );

    conv_sequencer #(
        .ADDR_W(2), .ROM_DEPTH(2), .LOAD_CYCLES(3), .MULT_CYCLES(3),
        .ADD_LEVELS(2), .ADD_CYCLES(2), .NUM_OUTPUTS(2)
    ) dut_wrap (
        .clk(clk), .reset(reset), .start(w_start), .abort(w_abort), .fifo_full(w_fifo_full),
        .busy(w_busy), .done(w_done), .ram_en(w_ram_en), .ram_addr(w_ram_addr),
        .rom_en(w_rom_en), .rom_addr(w_rom_addr), .dp_mult(w_dp_mult), .dp_add(w_dp_add),
        .fifo_wr(w_fifo_wr), .fifo_rd(w_fifo_rd), .out_count(w_out_count)
    );

    assign obs = {busy, done, ram_en, ram_addr, rom_en, rom_addr, dp_mult, dp_add,
                  fifo_wr, fifo_rd, out_count};

    // Expand one job into its expected per-cycle outputs and the fifo_full drive pattern.
    // stall[n] = number of edges at which the FIFO is reported full for output n.
    function automatic void gen_job(input int stall [NO], input bit noise);
        obs_t e;
        int cnt;
        int ra;
        int st_idx [NO];
        cnt = 0;
        ra  = 0;
        exp_q.delete();
        ff_q.delete();
        for (int n = 0; n < NO; n++) begin
            for (int l = 0; l < LC; l++) begin
                e = '0; e.busy = 1'b1; e.ram_en = 1'b1; e.rom_en = 1'b1;
                e.ram_addr = AW'(ra % 1024); e.rom_addr = 1'(l % RD); e.out_count = 2'(cnt);
                exp_q.push_back(e);
                ra = ra + 1;
            end
            for (int m = 0; m < MC; m++) begin
                e = '0; e.busy = 1'b1; e.dp_mult = 1'b1; e.ram_addr = AW'(ra % 1024);
                e.out_count = 2'(cnt);
                exp_q.push_back(e);
            end
            for (int lv = 0; lv < AL; lv++) begin
                for (int c = 0; c < AC; c++) begin
                    e = '0; e.busy = 1'b1; e.dp_add = 2'(1 << lv); e.ram_addr = AW'(ra % 1024);
                    e.out_count = 2'(cnt);
                    exp_q.push_back(e);
                end
            end
            st_idx[n] = exp_q.size();
            for (int s = 0; s < stall[n]; s++) begin
                e = '0; e.busy = 1'b1; e.ram_addr = AW'(ra % 1024); e.out_count = 2'(cnt);
                exp_q.push_back(e);
            end
            cnt = cnt + 1;
            e = '0; e.busy = 1'b1; e.fifo_wr = 1'b1; e.ram_addr = AW'(ra % 1024);
            e.out_count = 2'(cnt);
            exp_q.push_back(e);
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1; e.fifo_rd = 1'b1; e.ram_addr = AW'(ra % 1024);
        e.out_count = 2'(cnt);
        exp_q.push_back(e);
        for (int i = 0; i < exp_q.size(); i++)
            ff_q.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
        // the edge entering STORE and every stalled STORE edge see a full FIFO
        for (int n = 0; n < NO; n++) begin
            for (int j = 0; j < stall[n]; j++) ff_q[st_idx[n] - 1 + j] = 1'b1;
            ff_q[st_idx[n] - 1 + stall[n]] = 1'b0;
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, obs_t'(0));
        end
        n_cmp++;
        if ({w_busy, w_ram_addr, w_out_count, w_fifo_wr} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_wrap_dut: got %b want 0", {w_busy, w_ram_addr, w_out_count, w_fifo_wr});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int st [NO];
        obs_t e;
        st = '{0, 0, 0};
        gen_job(st, 1'b0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            fifo_full = ff_q[k];
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL basic cycle %0d: got %h want %h", k + 1, obs, exp_q[k]);
            end
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        e = '0; e.out_count = 2'(NO);
        n_cmp++;
        if ((obs & idle_mask) !== (e & idle_mask)) begin
            n_fail++;
            $display("FAIL basic_idle_after: got %h want %h", obs & idle_mask, e & idle_mask);
        end
    endtask

    task automatic test_start_abort_idle();
        obs_t e;
        e = '0; e.out_count = 2'(NO);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ((obs & idle_mask) !== (e & idle_mask)) begin
                n_fail++;
                $display("FAIL start_abort_idle cycle %0d: got %h want %h", k, obs & idle_mask, e & idle_mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_pressure();
        int st [NO];
        st = '{5, 0, 0};
        gen_job(st, 1'b0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            fifo_full = ff_q[k];
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL back_pressure cycle %0d: got %h want %h", k + 1, obs, exp_q[k]);
            end
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_pressure_len: busy got %b want 0 after 36 cycles", busy);
        end
    endtask

    // random stalls, random fifo_full noise, and start toggling while busy
    task automatic test_random_stalls();
        int st [NO];
        obs_t e;
        for (int it = 0; it < 4; it++) begin
            for (int n = 0; n < NO; n++) st[n] = int'($urandom_range(0, 4));
            gen_job(st, 1'b1);
            start = 1'b1; @(posedge clk); #1;
            for (int k = 0; k < exp_q.size(); k++) begin
                fifo_full = ff_q[k];
                start = 1'($urandom_range(0, 1));
                n_cmp++;
                if (obs !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL random it %0d cycle %0d: got %h want %h", it, k + 1, obs, exp_q[k]);
                end
                @(posedge clk); #1;
            end
            start = 1'b0; fifo_full = 1'b0;
            e = '0; e.out_count = 2'(NO);
            n_cmp++;
            if ((obs & idle_mask) !== (e & idle_mask)) begin
                n_fail++;
                $display("FAIL random_idle it %0d: got %h want %h", it, obs & idle_mask, e & idle_mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st [NO];
        st = '{0, 0, 0};
        gen_job(st, 1'b0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            fifo_full = ff_q[k];
            @(posedge clk); #1;
        end
        // first IDLE cycle after FINISH: start again immediately
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            fifo_full = ff_q[k];
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", k + 1, obs, exp_q[k]);
            end
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_abort();
        int st [NO];
        int a;
        obs_t e;
        st = '{0, 0, 0};
        gen_job(st, 1'b1);
        a = 12 + int'($urandom_range(0, 2));
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k <= a; k++) begin
            fifo_full = ff_q[k];
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL abort_pre cycle %0d: got %h want %h", k + 1, obs, exp_q[k]);
            end
            if (k == a) abort = 1'b1;
            @(posedge clk); #1;
        end
        abort = 1'b0; fifo_full = 1'b0;
        e = '0; e.out_count = 2'd1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ((obs & idle_mask) !== (e & idle_mask)) begin
                n_fail++;
                $display("FAIL abort_idle cycle %0d: got %h want %h", k, obs & idle_mask, e & idle_mask);
            end
            @(posedge clk); #1;
        end
        gen_job(st, 1'b0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            fifo_full = ff_q[k];
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL abort_rerun cycle %0d: got %h want %h", k + 1, obs, exp_q[k]);
            end
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_reset_mid_add();
        int st [NO];
        st = '{0, 0, 0};
        gen_job(st, 1'b0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL reset_mid_pre cycle %0d: got %h want %h", k + 1, obs, exp_q[k]);
            end
            if (k == 6) reset = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (obs !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_add: got %h want %h", obs, obs_t'(0));
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_addr_wrap();
        int nb;
        int idx;
        int nwr;
        int ndone;
        logic [1:0] ea;
        logic [0:0] er;
        nb = 0; idx = 0; nwr = 0; ndone = 0;
        w_start = 1'b1; @(posedge clk); #1; w_start = 1'b0;
        for (int k = 0; k < 100 && w_busy === 1'b1; k++) begin
            nb++;
            if (w_fifo_wr === 1'b1) nwr++;
            if (w_done === 1'b1) ndone++;
            if (w_ram_en === 1'b1) begin
                ea = 2'(idx % 4);
                er = 1'((idx % 3) % 2);
                n_cmp++;
                if ({w_ram_addr, w_rom_addr} !== {ea, er}) begin
                    n_fail++;
                    $display("FAIL addr_wrap load %0d: got %h/%h want %h/%h", idx, w_ram_addr, w_rom_addr, ea, er);
                end
                idx++;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (nb !== 23 || idx !== 6) begin
            n_fail++;
            $display("FAIL addr_wrap_len: busy %0d loads %0d want 23 6", nb, idx);
        end
        n_cmp++;
        if (nwr !== 2 || ndone !== 1 || w_out_count !== 2'd2) begin
            n_fail++;
            $display("FAIL addr_wrap_count: wr %0d done %0d cnt %0d want 2 1 2", nwr, ndone, w_out_count);
        end
    endtask

    initial begin
        idle_mask = '1;
        idle_mask.ram_addr = '0;
        idle_mask.rom_addr = '0;
        start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
        w_start = 1'b0; w_abort = 1'b0; w_fifo_full = 1'b0;
        reset = 1'b1;
        test_reset();
        test_basic();
        test_start_abort_idle();
        test_back_pressure();
        test_random_stalls();
        test_back_to_back();
        test_abort();
        test_reset_mid_add();
        test_addr_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
